// File: rtl/bcd_a_bin.sv
// bcd_a_bin: 3-digit BCD to 10-bit binary by reverse double dabble (optional digit check under BCD_A_BIN_CHECK_EN)
module bcd_a_bin (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bcd,
  output logic [9:0]  bin,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [21:0] work_q, work_d, sh, corr;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bin_q, bin_d;
  logic        done_q, done_d, err_q, err_d, bad;
  function automatic logic [3:0] fix(input logic [3:0] x);
    return x >= 4'd8 ? x - 4'd3 : x;
  endfunction
`ifdef BCD_A_BIN_CHECK_EN
  assign bad = (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
`else
  assign bad = 1'b0;
`endif
  assign sh = work_q >> 1;
  assign corr = {fix(sh[21:18]), fix(sh[17:14]), fix(sh[13:10]), sh[9:0]};
  // next-state: accept/reject in IDLE, one shift-and-correct step per SHIFT cycle
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    err_d = err_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      if (bad) begin
        bin_d = '0;
        err_d = 1'b1;
        done_d = 1'b1;
      end else begin
        work_d = {bcd, 10'd0};
        cnt_d = '0;
        state_d = SHIFT;
      end
    end else if (state_q == SHIFT) begin
      work_d = corr;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd9) begin
        bin_d = corr[9:0];
        err_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  // state registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      cnt_q <= '0;
      bin_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign bin = bin_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;
`ifdef BCD_A_BIN_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_a_bin.sv
// tb_bcd_a_bin: directed self-checking bench for bcd_a_bin
module tb_bcd_a_bin;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [11:0] bcd = '0;
  logic [9:0] bin;
  logic busy, done, err;
  int checks = 0, errors = 0, cyc = 0, lat, t0, n;
  bcd_a_bin dut (.clk(clk), .rst(rst), .start(start), .bcd(bcd), .bin(bin), .busy(busy), .done(done), .err(err));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic wait_done(output int l);
    l = 0;
    while (!done && l < 30) begin
      tick();
      l++;
    end
    check("done_timeout", int'(done), 1);
  endtask
  task automatic convert(input logic [11:0] v, output int l);
    bcd = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(l);
  endtask
  initial begin
    tick();
    tick();
    check("rst_bin", int'(bin), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    tick();
    bcd = 12'h999;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("999_busy", int'(busy), 1);
    wait_done(lat);
    check("999_lat", lat, 10);
    check("999_bin", int'(bin), 999);
    check("999_err", int'(err), 0);
    check("999_busy_end", int'(busy), 0);
    tick();
    check("999_done_pulse", int'(done), 0);
    check("999_hold", int'(bin), 999);
    start = 1'b1;
    bcd = 12'h000;
    tick();
    bcd = 12'h255;
    wait_done(lat);
    check("b2b_0", int'(bin), 0);
    t0 = cyc;
    tick();
    bcd = 12'h100;
    wait_done(lat);
    check("b2b_255", int'(bin), 255);
    check("b2b_gap1", cyc - t0, 11);
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("b2b_100", int'(bin), 100);
    check("b2b_gap2", cyc - t0, 11);
    tick();
    for (int i = 0; i < 1000; i++) begin
      convert({4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)}, lat);
      check("sweep_bin", int'(bin), i);
      check("sweep_err", int'(err), 0);
    end
    tick();
`ifdef BCD_A_BIN_CHECK_EN
    bcd = 12'h1A0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_done", int'(done), 1);
    check("bad_err", int'(err), 1);
    check("bad_bin", int'(bin), 0);
    check("bad_busy", int'(busy), 0);
    tick();
    check("bad_done_pulse", int'(done), 0);
    check("bad_busy2", int'(busy), 0);
`else
    convert(12'h1A0, lat);
    check("nochk_lat", lat, 10);
    check("nochk_err", int'(err), 0);
`endif
    tick();
    bcd = 12'h512;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    bcd = 12'h777;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", lat + 3, 10);
    check("ign_bin", int'(bin), 512);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n += int'(done);
    end
    check("ign_no_second", n, 0);
    bcd = 12'h999;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_bin", int'(bin), 0);
    check("arst_done", int'(done), 0);
    check("arst_err", int'(err), 0);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n += int'(done) + int'(busy);
    end
    check("arst_no_done", n, 0);
    convert(12'h042, lat);
    check("post_rst_bin", int'(bin), 42);
    check("post_rst_lat", lat, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
